obi_data_mem_responder: RTL and testbench

//  Memory-side OBI responder for the core's data port: takes data_req/addr/we/be/wdata from the core
//  and returns gnt, then rvalid/rdata in order. Word-addressed SRAM model with a grant-delay FSM and a

---
 rtl/obi_mem_pkg.sv | 19 +
 rtl/obi_data_mem_responder_if.sv | 24 ++
 rtl/obi_mem_rsp_pipe.sv | 27 ++
 rtl/obi_data_mem_responder.sv | 139 +++++++++++++
 tb/tb_obi_data_mem_responder.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/obi_mem_pkg.sv
// Shared types and widths for the OBI data-memory responder.
package obi_mem_pkg;

  localparam int unsigned OBI_DW  = 32;
  localparam int unsigned OBI_BEW = 4;

  // One response pipeline slot
  typedef struct packed {
    logic              valid;
    logic [OBI_DW-1:0] rdata;
  } obi_rsp_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GRANT
  } gnt_state_e;

endpackage

// File: rtl/obi_data_mem_responder_if.sv
// OBI data-port bundle between the core (master) and the memory responder (slave).
interface obi_data_mem_responder_if;
  import obi_mem_pkg::*;

  logic                data_req_i;
  logic [31:0]         data_addr_i;
  logic                data_we_i;
  logic [OBI_BEW-1:0]  data_be_i;
  logic [OBI_DW-1:0]   data_wdata_i;
  logic                data_gnt_o;
  logic                data_rvalid_o;
  logic [OBI_DW-1:0]   data_rdata_o;

  modport master (
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o
  );

  modport slave (
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o
  );

endinterface

// File: rtl/obi_mem_rsp_pipe.sv
// Fixed-latency response shift register; the last stage drives rvalid/rdata.
module obi_mem_rsp_pipe
  import obi_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst_i,
  input  obi_rsp_t rsp_in,
  output obi_rsp_t rsp_out
);

  obi_rsp_t stage [DEPTH];

  // Shift responses one slot per cycle; reset drops everything in flight
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= rsp_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign rsp_out = stage[DEPTH-1];

endmodule

// File: rtl/obi_data_mem_responder.sv
// Memory-side OBI responder: word-addressed SRAM, grant-delay FSM, in-flight
// limit and fixed-latency in-order responses.
// Optional feature: define OBI_MEM_RAND_STALL_EN for LFSR-driven random grant stalls.
module obi_data_mem_responder
  import obi_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter int unsigned GNT_DELAY      = 0,
  parameter int unsigned RVALID_LATENCY = 1,
  parameter int unsigned OUTSTANDING    = 2,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input logic                     clk,
  input logic                     rst_i,
  obi_data_mem_responder_if.slave bus
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W  = $clog2(OUTSTANDING + 1);
  localparam int unsigned WCNT_W = (GNT_DELAY > 1) ? $clog2(GNT_DELAY) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'((GNT_DELAY > 0) ? GNT_DELAY - 1 : 0);

  gnt_state_e          state;
  logic [WCNT_W-1:0]   wcnt;
  logic [CNT_W-1:0]    cnt;
  logic                stall;
  logic                space_ok;
  logic                gnt;
  logic                accept;
  logic                retire;
  logic [AW-1:0]       idx;
  obi_rsp_t            rsp_in;
  obi_rsp_t            rsp_out;
  logic [OBI_DW-1:0]   mem [DEPTH_WORDS];
  logic                unused_addr;

  // Upper address bits wrap modulo the depth; byte offset is ignored
  assign idx         = bus.data_addr_i[AW+1:2];
  assign unused_addr = ^{bus.data_addr_i[31:AW+2], bus.data_addr_i[1:0]};

`ifdef OBI_MEM_RAND_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11, free-running from the seed
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  logic unused_seed;

  assign stall       = 1'b0;
  assign unused_seed = ^LFSR_SEED;
`endif

  // Registered count is compared, so a same-cycle retire does not reopen the grant
  assign space_ok = (cnt < CNT_W'(OUTSTANDING));

  // Grant decode; never granted without a request or during reset
  always_comb begin
    gnt = 1'b0;
    if (!rst_i && bus.data_req_i && space_ok && !stall) begin
      case (state)
        IDLE:    gnt = (GNT_DELAY == 0);
        WAIT:    gnt = (wcnt == '0);
        GRANT:   gnt = 1'b1;
        default: gnt = 1'b0;
      endcase
    end
  end

  assign accept = gnt;
  assign retire = rsp_out.valid;

  // Grant-delay FSM; the last wait cycle already offers the grant
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.data_req_i && (GNT_DELAY != 0)) begin
            wcnt  <= WAIT_LOAD;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!bus.data_req_i)  state <= IDLE;
          else if (wcnt == '0)  state <= accept ? IDLE : GRANT;
          else                  wcnt  <= wcnt - WCNT_W'(1);
        end
        GRANT: begin
          if (!bus.data_req_i || accept) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In-flight transaction counter
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i)                  cnt <= '0;
    else if (accept && !retire) cnt <= cnt + CNT_W'(1);
    else if (!accept && retire) cnt <= cnt - CNT_W'(1);
  end

  // Byte-enabled write into the backing store; contents survive reset
  always_ff @(posedge clk) begin
    if (accept && bus.data_we_i) begin
      for (int b = 0; b < OBI_BEW; b++) begin
        if (bus.data_be_i[b]) mem[idx][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
      end
    end
  end

  // Read data is sampled before this edge's write lands; writes respond with zero
  always_comb begin
    rsp_in       = '0;
    rsp_in.valid = accept;
    if (accept && !bus.data_we_i) rsp_in.rdata = mem[idx];
  end

  obi_mem_rsp_pipe #(
    .DEPTH (RVALID_LATENCY)
  ) u_rsp_pipe (
    .clk     (clk),
    .rst_i   (rst_i),
    .rsp_in  (rsp_in),
    .rsp_out (rsp_out)
  );

  assign bus.data_gnt_o    = gnt;
  assign bus.data_rvalid_o = rsp_out.valid;
  assign bus.data_rdata_o  = rsp_out.rdata;

endmodule

// File: tb/tb_obi_data_mem_responder.sv
// Directed bench for obi_data_mem_responder across four parameter sets.
module tb_obi_data_mem_responder;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [31:0] wd [3];

  always #5 clk = ~clk;

  obi_data_mem_responder_if a_if ();
  obi_data_mem_responder_if b_if ();
  obi_data_mem_responder_if c_if ();
  obi_data_mem_responder_if d_if ();

  obi_data_mem_responder #(.GNT_DELAY(0), .RVALID_LATENCY(1), .OUTSTANDING(2))
    dut_a (.clk(clk), .rst_i(rst), .bus(a_if));
  obi_data_mem_responder #(.GNT_DELAY(3), .RVALID_LATENCY(2), .OUTSTANDING(2))
    dut_b (.clk(clk), .rst_i(rst), .bus(b_if));
  obi_data_mem_responder #(.GNT_DELAY(0), .RVALID_LATENCY(4), .OUTSTANDING(1))
    dut_c (.clk(clk), .rst_i(rst), .bus(c_if));
  obi_data_mem_responder #(.GNT_DELAY(0), .RVALID_LATENCY(3), .OUTSTANDING(3))
    dut_d (.clk(clk), .rst_i(rst), .bus(d_if));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wd[0] = 32'hA0A0A0A0;
    wd[1] = 32'hB1B1B1B1;
    wd[2] = 32'hC2C2C2C2;
    a_if.data_req_i = 1'b0; a_if.data_addr_i = '0; a_if.data_we_i = 1'b0; a_if.data_be_i = 4'hF; a_if.data_wdata_i = '0;
    b_if.data_req_i = 1'b0; b_if.data_addr_i = '0; b_if.data_we_i = 1'b0; b_if.data_be_i = 4'hF; b_if.data_wdata_i = '0;
    c_if.data_req_i = 1'b0; c_if.data_addr_i = '0; c_if.data_we_i = 1'b0; c_if.data_be_i = 4'hF; c_if.data_wdata_i = '0;
    d_if.data_req_i = 1'b0; d_if.data_addr_i = '0; d_if.data_we_i = 1'b0; d_if.data_be_i = 4'hF; d_if.data_wdata_i = '0;

    // Reset: request held high must not be granted
    rst = 1'b1;
    a_if.data_req_i = 1'b1;
    @(negedge clk);
    chk("rst_gnt",    32'(a_if.data_gnt_o),    32'h0);
    chk("rst_rvalid", 32'(a_if.data_rvalid_o), 32'h0);
    chk("rst_rdata",  a_if.data_rdata_o,       32'h0);
    step();
    rst = 1'b0;
    a_if.data_req_i = 1'b0;
    step();

    // Test 1: write then read 0x10, zero grant delay, latency 1
    a_if.data_req_i = 1'b1; a_if.data_we_i = 1'b1; a_if.data_addr_i = 32'h10;
    a_if.data_be_i = 4'hF; a_if.data_wdata_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_wr_gnt", 32'(a_if.data_gnt_o), 32'h1);
    step();
    a_if.data_we_i = 1'b0;
    @(negedge clk);
    chk("t1_wr_rvalid", 32'(a_if.data_rvalid_o), 32'h1);
    chk("t1_wr_rdata",  a_if.data_rdata_o,       32'h0);
    chk("t1_rd_gnt",    32'(a_if.data_gnt_o),    32'h1);
    step();
    a_if.data_req_i = 1'b0;
    @(negedge clk);
    chk("t1_rd_rvalid", 32'(a_if.data_rvalid_o), 32'h1);
    chk("t1_rd_rdata",  a_if.data_rdata_o,       32'hDEADBEEF);
    chk("t1_idle_gnt",  32'(a_if.data_gnt_o),    32'h0);
    step();
    @(negedge clk);
    chk("t1_rvalid_drop", 32'(a_if.data_rvalid_o), 32'h0);
    chk("t1_rdata_zero",  a_if.data_rdata_o,       32'h0);

    // Test 2: partial byte-enable write
    step();
    a_if.data_req_i = 1'b1; a_if.data_we_i = 1'b1; a_if.data_be_i = 4'b0100;
    a_if.data_wdata_i = 32'h00AA0000;
    @(negedge clk);
    chk("t2_wr_gnt", 32'(a_if.data_gnt_o), 32'h1);
    step();
    a_if.data_we_i = 1'b0; a_if.data_be_i = 4'hF;
    @(negedge clk);
    chk("t2_wr_rdata", a_if.data_rdata_o, 32'h0);
    step();
    a_if.data_req_i = 1'b0;
    @(negedge clk);
    chk("t2_rd_rdata", a_if.data_rdata_o, 32'hDEAABEEF);

    // Test 5: address wrap, then back-to-back reads
    step();
    a_if.data_req_i = 1'b1; a_if.data_we_i = 1'b1; a_if.data_addr_i = 32'h1000;
    a_if.data_wdata_i = 32'h5A5A5A5A;
    step();
    a_if.data_we_i = 1'b0; a_if.data_addr_i = 32'h0;
    step();
    a_if.data_addr_i = 32'h10;
    @(negedge clk);
    chk("t5_wrap_rvalid", 32'(a_if.data_rvalid_o), 32'h1);
    chk("t5_wrap_rdata",  a_if.data_rdata_o,       32'h5A5A5A5A);
    step();
    a_if.data_req_i = 1'b0;
    @(negedge clk);
    chk("t5_b2b_rvalid", 32'(a_if.data_rvalid_o), 32'h1);
    chk("t5_b2b_rdata",  a_if.data_rdata_o,       32'hDEAABEEF);
    step();
    @(negedge clk);
    chk("t5_end_rvalid", 32'(a_if.data_rvalid_o), 32'h0);

    // Test 3: grant delay 3, latency 2, back-to-back request pays the delay again
    step();
    b_if.data_req_i = 1'b1; b_if.data_we_i = 1'b1; b_if.data_addr_i = 32'h20;
    b_if.data_wdata_i = 32'h12345678;
    for (int t = 0; t < 10; t++) begin
      if (t == 4) b_if.data_we_i = 1'b0;
      if (t == 8) b_if.data_req_i = 1'b0;
      @(negedge clk);
      chk($sformatf("t3_gnt_c%0d", t),    32'(b_if.data_gnt_o),    32'(t == 3 || t == 7));
      chk($sformatf("t3_rvalid_c%0d", t), 32'(b_if.data_rvalid_o), 32'(t == 5 || t == 9));
      if (t == 5) chk("t3_wr_rdata", b_if.data_rdata_o, 32'h0);
      if (t == 9) chk("t3_rd_rdata", b_if.data_rdata_o, 32'h12345678);
      step();
    end

    // Test 4: one outstanding, latency 4; three writes then three reads
    c_if.data_req_i = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int t = 0; t < 15; t++) begin
        c_if.data_we_i    = (pass == 0);
        c_if.data_addr_i  = 32'((t / 5) * 4);
        c_if.data_wdata_i = wd[t / 5];
        @(negedge clk);
        chk($sformatf("t4_p%0d_gnt_c%0d", pass, t),    32'(c_if.data_gnt_o),    32'(t % 5 == 0));
        chk($sformatf("t4_p%0d_rvalid_c%0d", pass, t), 32'(c_if.data_rvalid_o), 32'(t % 5 == 4));
        if (t % 5 == 4)
          chk($sformatf("t4_p%0d_rdata_c%0d", pass, t), c_if.data_rdata_o,
              (pass == 0) ? 32'h0 : wd[t / 5]);
        step();
      end
    end
    c_if.data_req_i = 1'b0;

    // Test 6: reset with two reads in flight drops both responses
    step();
    d_if.data_req_i = 1'b1; d_if.data_we_i = 1'b0; d_if.data_addr_i = 32'h0;
    @(negedge clk);
    chk("t6_gnt0", 32'(d_if.data_gnt_o), 32'h1);
    step();
    d_if.data_addr_i = 32'h4;
    @(negedge clk);
    chk("t6_gnt1", 32'(d_if.data_gnt_o), 32'h1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_gnt",    32'(d_if.data_gnt_o),    32'h0);
    chk("t6_rst_rvalid", 32'(d_if.data_rvalid_o), 32'h0);
    chk("t6_rst_rdata",  d_if.data_rdata_o,       32'h0);
    step();
    rst = 1'b0;
    d_if.data_req_i = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk($sformatf("t6_post_rvalid_c%0d", t), 32'(d_if.data_rvalid_o), 32'h0);
      step();
    end
    d_if.data_req_i = 1'b1; d_if.data_we_i = 1'b1; d_if.data_wdata_i = 32'h77;
    @(negedge clk);
    chk("t6_after_gnt", 32'(d_if.data_gnt_o), 32'h1);
    step();
    d_if.data_req_i = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      chk($sformatf("t6_after_rvalid_c%0d", t), 32'(d_if.data_rvalid_o), 32'(t == 3));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
